eth_smi_target: RTL and testbench
=================================

Name: eth_smi_target

Overview:
- MDIO/SMI management-frame responder: the PHY-side end of the management interface driven by the team's SMI master.
- Oversamples MDC and MDIO in the clk_mac domain, decodes IEEE 802.3 clause-22 frames, and serves a 32x16 PHY register model.
- Used as a loopback/sim PHY model and for board bring-up without a real PHY.
- Exposes committed writes to surrounding logic.

Parameters:
PHY_ADDR, 5'd1, PHY address this target answers to.
PHY_ID1, 16'h0007, read-only value of reg 2.
PHY_ID2, 16'hC0F1, read-only value of reg 3.
REG0_DEFAULT, 16'h3100, reset/soft-reset value of reg 0.
PREAMBLE_BITS, 32, consecutive 1s required before a start is accepted.

Ports:
clk_mac  in  1  system clock; must be >= 8x the MDC frequency.
rst  in  1  synchronous, active-high reset.
mdc  in  1  management clock from the master (asynchronous).
mdio_i  in  1  MDIO input (asynchronous).
mdio_o  out  1  MDIO output value.
mdio_oe  out  1  MDIO output enable; 1 = target drives the pad.
stat_bmsr  in  16  live value returned for reads of reg 1.
reg_wr  out  1  1-cycle pulse when a write to a writable register commits.
reg_waddr  out  5  address of the committed write.
reg_wdata  out  16  data of the committed write.
frame_err  out  1  1-cycle pulse on a malformed frame (bad ST or bad OP).

Behaviour:
- Synchronisation: mdc and mdio_i each pass through 2 flops.
- Edge detect on the synchronised mdc gives rise/fall strobes.
- All MDIO sampling happens on rise; all drive changes happen on fall.
- Reset values: mdio_o=0, mdio_oe=0, reg_wr=0, reg_waddr=0, reg_wdata=0, frame_err=0, state=IDLE, preamble count=0. Array: reg0=REG0_DEFAULT; regs 4..31 = 0.
- Register map:
  - reg 1 reads stat_bmsr.
  - regs 2 and 3 read PHY_ID1 and PHY_ID2.
  - Regs 1-3 are read-only: writes are discarded and produce no reg_wr pulse.
  - All other registers are read/write.
  - reg0 bit15 is self-clearing soft reset: writing 1 restores all array defaults in the commit cycle; reg0 bit15 always reads 0.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA. A 4-bit bit counter runs within each field.
- IDLE:
  - Counts consecutive sampled 1s, saturating at PREAMBLE_BITS.
  - A sampled 0 with count >= PREAMBLE_BITS goes to ST; any other 0 clears the count.
- ST: next sampled bit must be 1, else frame_err and go to IDLE with count cleared.
- OP: 2 bits. 10 = read, 01 = write; 00 or 11 gives frame_err and IDLE.
- PHYAD: 5 bits, MSB first, compared with PHY_ADDR. On mismatch the frame is still consumed to its end, but nothing is driven and nothing is written.
- REGAD: 5 bits, MSB first. On the rise sampling the last bit, a read with matching PHYAD snapshots the read value into a 16-bit shift register.
- TA, read with matching PHYAD:
  - First fall after REGAD: oe stays 0.
  - Second fall: oe=1, mdio_o=0.
- RDATA:
  - Each subsequent fall shifts out D15..D0.
  - The fall following the rise that samples D0 sets oe=0 and the state returns to IDLE.
- TA, write: the two sampled TA bits are ignored.
- WDATA:
  - 16 bits are sampled MSB first.
  - On the rise sampling D0 the write commits when PHYAD matches and the register is writable.
  - reg_wr, reg_waddr and reg_wdata assert on the next clk_mac cycle for exactly 1 cycle, then the state returns to IDLE.
- Preamble count: cleared on every frame end, so each frame needs its own full preamble.
- Mid-frame rst: oe drops to 0 on the next clock edge, the state machine goes to IDLE, and the array is reinitialised.
- A frame in progress when rst deasserts is ignored until a new preamble is seen.
- mdio_oe may only be 1 between the second TA fall and the fall after D0.

Decomposition:
- Shared package eth_smi_pkg holds:
  - the OP codes (2'b10 read, 2'b01 write) and the ST pattern;
  - clause-22 register indices (BMCR=0, BMSR=1, ID1=2, ID2=3);
  - the frame field widths, so master and target share one definition.
- One natural sub-module: eth_smi_target_regs. It holds the 32x16 array with defaults, the read-only masking, the reg0 soft reset and the read mux.
- The frame FSM stays in eth_smi_target.

Test Plan:
- Read reg 2 (32 ones, 01 10 00001 00010), MDC = clk/16 -> from the second TA bit the target drives 0 then 0x0007 MSB first; oe falls after D0.
- Write reg 4 = 0x01E1, then read reg 4 -> reg_wr pulses once with addr=4, data=0x01E1; the read returns 0x01E1.
- stat_bmsr=0x782D, read reg 1 -> returns 0x782D. Write 0xFFFF to reg 1 -> no reg_wr; a following read still returns stat_bmsr.
- Read with PHYAD=2, and a frame with only 31 preamble ones -> mdio_oe stays 0 throughout; no reg_wr. OP=11 -> frame_err pulse.
- Write reg 4=0x1234, then write reg0=0x8000, then read reg 0 and reg 4 -> 0x3100 and 0x0000.
- Assert rst during RDATA bit 7 -> mdio_oe=0 the next cycle; a following valid read of reg 0 returns 0x3100.

Source files
------------

// File: rtl/eth_smi_pkg.sv
// Clause-22 SMI definitions shared by the management master and target.
package eth_smi_pkg;

  localparam logic [1:0] SMI_ST       = 2'b01;
  localparam logic [1:0] SMI_OP_READ  = 2'b10;
  localparam logic [1:0] SMI_OP_WRITE = 2'b01;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

  localparam int unsigned SMI_OP_BITS   = 2;
  localparam int unsigned SMI_ADDR_BITS = 5;
  localparam int unsigned SMI_TA_BITS   = 2;
  localparam int unsigned SMI_DATA_BITS = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSt,
    StOp,
    StPhyad,
    StRegad,
    StTa,
    StRdata,
    StWdata
  } smi_state_e;

  function automatic logic smi_reg_writable(input logic [4:0] addr);
    return !((addr == REG_BMSR) || (addr == REG_ID1) || (addr == REG_ID2));
  endfunction

endpackage

// File: rtl/eth_smi_target_regs.sv
// 32x16 PHY register model: defaults, read-only masking, reg0 soft reset and read mux.
module eth_smi_target_regs
  import eth_smi_pkg::*;
#(
  parameter logic [15:0] PHY_ID1      = 16'h0007,
  parameter logic [15:0] PHY_ID2      = 16'hC0F1,
  parameter logic [15:0] REG0_DEFAULT = 16'h3100
) (
  input  logic        clk_mac,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [15:0] stat_bmsr,
  output logic [15:0] rdata
);

  logic [15:0] mem_q [32];
  logic        soft_rst;

  assign soft_rst = we && (waddr == REG_BMCR) && wdata[15];

  always_ff @(posedge clk_mac) begin
    if (rst || soft_rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= (i == 0) ? REG0_DEFAULT : 16'h0000;
      end
    end else if (we && smi_reg_writable(waddr)) begin
      mem_q[waddr] <= (waddr == REG_BMCR) ? {1'b0, wdata[14:0]} : wdata;
    end
  end

  // Reg0 bit15 is self-clearing, so it never reads back as 1.
  always_comb begin
    rdata = mem_q[raddr];
    case (raddr)
      REG_BMCR: rdata = {1'b0, mem_q[REG_BMCR][14:0]};
      REG_BMSR: rdata = stat_bmsr;
      REG_ID1:  rdata = PHY_ID1;
      REG_ID2:  rdata = PHY_ID2;
      default:  ;
    endcase
  end

endmodule

// File: rtl/eth_smi_target.sv
// MDIO/SMI clause-22 target: oversamples MDC/MDIO in clk_mac and runs the frame FSM.
module eth_smi_target
  import eth_smi_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter logic [15:0] PHY_ID1       = 16'h0007,
  parameter logic [15:0] PHY_ID2       = 16'hC0F1,
  parameter logic [15:0] REG0_DEFAULT  = 16'h3100,
  parameter int unsigned PREAMBLE_BITS = 32
) (
  input  logic        clk_mac,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] stat_bmsr,
  output logic        reg_wr,
  output logic [4:0]  reg_waddr,
  output logic [15:0] reg_wdata,
  output logic        frame_err
);

  localparam int unsigned    PreW     = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PreW-1:0] PreMax  = PreW'(PREAMBLE_BITS);
  localparam logic [3:0]     AddrLast = 4'(SMI_ADDR_BITS - 1);
  localparam logic [3:0]     OpLast   = 4'(SMI_OP_BITS - 1);
  localparam logic [3:0]     TaLast   = 4'(SMI_TA_BITS - 1);
  localparam logic [3:0]     DataLast = 4'(SMI_DATA_BITS - 1);

  logic mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic mdio_s1_q, mdio_s2_q;
  logic mdc_rise, mdc_fall, mdio_s;

  smi_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic          op_hi_q, op_hi_d;
  logic          is_read_q, is_read_d;
  logic [4:0]    phyad_q, phyad_d;
  logic [4:0]    regad_q, regad_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          last_q, last_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          reg_wr_q, reg_wr_d;
  logic [4:0]    reg_waddr_q, reg_waddr_d;
  logic [15:0]   reg_wdata_q, reg_wdata_d;
  logic          frame_err_q, frame_err_d;

  logic [4:0]    rd_addr;
  logic [15:0]   rd_data;
  logic          phy_match;

  assign mdc_rise  = mdc_s2_q & ~mdc_s3_q;
  assign mdc_fall  = ~mdc_s2_q & mdc_s3_q;
  assign mdio_s    = mdio_s2_q;
  assign phy_match = (phyad_q == PHY_ADDR);
  // Address as it stands once the last REGAD bit is shifted in.
  assign rd_addr   = {regad_q[3:0], mdio_s};

  eth_smi_target_regs #(
    .PHY_ID1      (PHY_ID1),
    .PHY_ID2      (PHY_ID2),
    .REG0_DEFAULT (REG0_DEFAULT)
  ) u_regs (
    .clk_mac   (clk_mac),
    .rst       (rst),
    .we        (reg_wr_q),
    .waddr     (reg_waddr_q),
    .wdata     (reg_wdata_q),
    .raddr     (rd_addr),
    .stat_bmsr (stat_bmsr),
    .rdata     (rd_data)
  );

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      mdc_s1_q    <= 1'b0;
      mdc_s2_q    <= 1'b0;
      mdc_s3_q    <= 1'b0;
      mdio_s1_q   <= 1'b0;
      mdio_s2_q   <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      op_hi_q     <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      shift_q     <= '0;
      wdata_q     <= '0;
      last_q      <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_oe_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      mdc_s1_q    <= mdc;
      mdc_s2_q    <= mdc_s1_q;
      mdc_s3_q    <= mdc_s2_q;
      mdio_s1_q   <= mdio_i;
      mdio_s2_q   <= mdio_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      shift_q     <= shift_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      reg_wr_q    <= reg_wr_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    reg_wr_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    frame_err_d = 1'b0;

    if (mdc_rise) begin
      unique case (state_q)
        StIdle: begin
          if (mdio_s) begin
            if (pre_cnt_q < PreMax) pre_cnt_d = pre_cnt_q + PreW'(1);
          end else begin
            // This 0 is the first ST bit when a full preamble preceded it.
            pre_cnt_d = '0;
            if (pre_cnt_q >= PreMax && mdio_s == SMI_ST[1]) state_d = StSt;
          end
        end
        StSt: begin
          bit_cnt_d = '0;
          if (mdio_s == SMI_ST[0]) begin
            state_d = StOp;
          end else begin
            frame_err_d = 1'b1;
            pre_cnt_d   = '0;
            state_d     = StIdle;
          end
        end
        StOp: begin
          if (bit_cnt_q != OpLast) begin
            op_hi_d   = mdio_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            bit_cnt_d = '0;
            if ({op_hi_q, mdio_s} == SMI_OP_READ) begin
              is_read_d = 1'b1;
              state_d   = StPhyad;
            end else if ({op_hi_q, mdio_s} == SMI_OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = StPhyad;
            end else begin
              frame_err_d = 1'b1;
              pre_cnt_d   = '0;
              state_d     = StIdle;
            end
          end
        end
        StPhyad: begin
          phyad_d = {phyad_q[3:0], mdio_s};
          if (bit_cnt_q == AddrLast) begin
            bit_cnt_d = '0;
            state_d   = StRegad;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StRegad: begin
          regad_d = rd_addr;
          if (bit_cnt_q == AddrLast) begin
            bit_cnt_d = '0;
            state_d   = StTa;
            if (is_read_q && phy_match) shift_d = rd_data;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StTa: begin
          if (bit_cnt_q == TaLast) begin
            bit_cnt_d = '0;
            last_d    = 1'b0;
            state_d   = is_read_q ? StRdata : StWdata;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StRdata: begin
          if (bit_cnt_q == DataLast) last_d = 1'b1;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end
        StWdata: begin
          wdata_d = {wdata_q[14:0], mdio_s};
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = StIdle;
            if (phy_match && smi_reg_writable(regad_q)) begin
              reg_wr_d    = 1'b1;
              reg_waddr_d = regad_q;
              reg_wdata_d = {wdata_q[14:0], mdio_s};
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end else if (mdc_fall) begin
      case (state_q)
        StTa: begin
          // Second TA fall: take the bus and drive the turnaround 0.
          if (bit_cnt_q == TaLast && is_read_q && phy_match) begin
            mdio_oe_d = 1'b1;
            mdio_o_d  = 1'b0;
          end
        end
        StRdata: begin
          if (last_q) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = StIdle;
          end else if (mdio_oe_q) begin
            mdio_o_d = shift_q[15];
            shift_d  = {shift_q[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign reg_wr    = reg_wr_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_eth_smi_target.sv
// Self-checking bench for eth_smi_target: bit-level SMI master plus register-map model.
module tb_eth_smi_target;

  localparam int          Half    = 8;
  localparam logic [4:0]  PhyAddr = 5'd1;

  logic        clk_mac = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [15:0] stat_bmsr;
  logic        reg_wr;
  logic [4:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        frame_err;
  logic        mdio_m;

  always #5 clk_mac = ~clk_mac;

  // Open-drain style bus: the master releases to 1 while the target reads.
  assign mdio_i = mdio_oe ? mdio_o : mdio_m;

  eth_smi_target dut (
    .clk_mac   (clk_mac),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .stat_bmsr (stat_bmsr),
    .reg_wr    (reg_wr),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_regs [32];
  wr_t         exp_wr_q [$];
  wr_t         mon_w;
  int          err_seen = 0;
  logic        drive_ok = 1'b0;
  logic        prev_wr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = (i == 0) ? 16'h3100 : 16'h0000;
  endfunction

  function automatic logic writable(input logic [4:0] a);
    return !(a == 5'd1 || a == 5'd2 || a == 5'd3);
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] a);
    case (a)
      5'd1:    return stat_bmsr;
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      default: return model_regs[a];
    endcase
  endfunction

  always @(negedge clk_mac) begin
    if (!rst) begin
      if (!drive_ok) check("oe_outside_window", mdio_oe, 1'b0);
      if (reg_wr) begin
        check("wr_single_cycle", prev_wr, 1'b0);
        check("wr_expected", exp_wr_q.size() > 0, 1'b1);
        if (exp_wr_q.size() > 0) begin
          mon_w = exp_wr_q.pop_front();
          check("wr_addr", reg_waddr, mon_w.a);
          check("wr_data", reg_wdata, mon_w.d);
        end
      end
      if (frame_err) err_seen++;
    end
    prev_wr = reg_wr;
  end

  // One MDC period: fall + drive, check just before the rise, then rise.
  task automatic send_bit(input logic b, input logic e_oe, input logic e_o, input logic clr_ok,
                          input logic do_rst, output logic got);
    mdc    = 1'b0;
    mdio_m = b;
    for (int c = 0; c < Half; c++) begin
      @(posedge clk_mac); #1;
      if (clr_ok && c == 5) drive_ok = 1'b0;
    end
    got = mdio_o;
    check("bit_oe", mdio_oe, e_oe);
    if (e_oe) check("bit_o", mdio_o, e_o);
    if (do_rst) begin
      rst = 1'b1;
      @(posedge clk_mac); #1;
      check("rst_drops_oe", mdio_oe, 1'b0);
      drive_ok = 1'b0;
      rst      = 1'b0;
    end
    mdc = 1'b1;
    for (int c = 0; c < Half; c++) begin
      @(posedge clk_mac); #1;
    end
  endtask

  task automatic do_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                          input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                          input int abort_at, output logic [15:0] rd);
    logic        valid, rmatch, wcommit, got, aborted, rd_tail, e_oe, e_o, b;
    logic [15:0] ev;
    logic [13:0] hdr;
    logic [17:0] tail;
    int          errs0;
    errs0   = err_seen;
    aborted = 1'b0;
    rd      = '0;
    valid   = (pre >= 32) && (st == 2'b01) && (op == 2'b10 || op == 2'b01);
    rmatch  = valid && (op == 2'b10) && (phy == PhyAddr);
    wcommit = valid && (op == 2'b01) && (phy == PhyAddr) && writable(ra);
    ev      = model_read(ra);
    rd_tail = (op == 2'b10);
    hdr     = {st, op, phy, ra};
    tail    = {2'b10, wd};
    if (wcommit) exp_wr_q.push_back({ra, wd});
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, got);
    for (int i = 13; i >= 0; i--) send_bit(hdr[i], 1'b0, 1'b0, 1'b0, 1'b0, got);
    if (rmatch) drive_ok = 1'b1;
    for (int k = 0; k < 18; k++) begin
      b    = rd_tail ? 1'b1 : tail[17-k];
      e_oe = rmatch && !aborted && (k >= 1);
      e_o  = (k >= 2) ? ev[17-k] : 1'b0;
      send_bit(b, e_oe, e_o, 1'b0, (k == abort_at), got);
      if (k >= 2) rd[17-k] = got;
      if (k == abort_at) begin
        aborted = 1'b1;
        model_reset();
        exp_wr_q.delete();
      end
    end
    send_bit(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, got);
    if (wcommit) begin
      if (ra == 5'd0 && wd[15]) model_reset();
      else model_regs[ra] = (ra == 5'd0) ? {1'b0, wd[14:0]} : wd;
    end
    check("frame_err_count", err_seen - errs0, (pre >= 32 && !valid) ? 1 : 0);
    check("wr_drained", exp_wr_q.size(), 0);
  endtask

  logic [15:0] rd;
  logic [1:0]  r_op;
  logic [4:0]  r_phy;
  int          r_sel;
  int          r_pre;

  initial begin
    rst       = 1'b1;
    mdc       = 1'b0;
    mdio_m    = 1'b1;
    stat_bmsr = 16'h0000;
    model_reset();
    repeat (4) @(posedge clk_mac);
    #1;
    check("rst_mdio_o", mdio_o, 1'b0);
    check("rst_mdio_oe", mdio_oe, 1'b0);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_waddr", reg_waddr, 5'd0);
    check("rst_reg_wdata", reg_wdata, 16'h0000);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    @(posedge clk_mac); #1;

    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd);
    check("read_id1", rd, 16'h0007);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0, -1, rd);
    check("read_id2", rd, 16'hC0F1);

    do_frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h01E1, -1, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
    check("read_reg4", rd, 16'h01E1);

    stat_bmsr = 16'h782D;
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd);
    check("read_bmsr", rd, 16'h782D);
    do_frame(32, 2'b01, 2'b01, 5'd1, 5'd1, 16'hFFFF, -1, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd);
    check("read_bmsr_after_wr", rd, 16'h782D);

    do_frame(32, 2'b01, 2'b10, 5'd2, 5'd0, 16'h0, -1, rd);
    do_frame(31, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
    do_frame(31, 2'b01, 2'b01, 5'd1, 5'd4, 16'hBEEF, -1, rd);
    do_frame(32, 2'b01, 2'b01, 5'd2, 5'd4, 16'hBEEF, -1, rd);
    do_frame(32, 2'b01, 2'b11, 5'd1, 5'd4, 16'h5555, -1, rd);
    do_frame(32, 2'b00, 2'b10, 5'd1, 5'd4, 16'h5555, -1, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
    check("reg4_untouched", rd, 16'h01E1);

    do_frame(36, 2'b01, 2'b01, 5'd1, 5'd0, 16'h1140, -1, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
    check("read_reg0_written", rd, 16'h1140);
    do_frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h1234, -1, rd);
    do_frame(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h8000, -1, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
    check("soft_rst_reg0", rd, 16'h3100);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
    check("soft_rst_reg4", rd, 16'h0000);

    do_frame(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h0100, -1, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, 10, rd);
    do_frame(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
    check("reg0_after_rst", rd, 16'h3100);

    for (int n = 0; n < 24; n++) begin
      r_sel     = $urandom_range(0, 9);
      r_op      = (r_sel == 0) ? 2'b11 : (r_sel == 1) ? 2'b00 : (r_sel < 6) ? 2'b10 : 2'b01;
      r_phy     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PhyAddr;
      r_pre     = ($urandom_range(0, 5) == 0) ? 31 : 32 + $urandom_range(0, 4);
      stat_bmsr = 16'($urandom());
      do_frame(r_pre, 2'b01, r_op, r_phy, 5'($urandom_range(0, 31)), 16'($urandom()), -1, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
